qar_adc_arbiter: RTL and testbench



---
 rtl/qar_adc_arbiter_pkg.sv | 24 ++
 rtl/qar_adc_arbiter_if.sv | 26 ++
 rtl/qar_adc_arbiter_rr_picker.sv | 26 ++
 rtl/qar_adc_arbiter.sv | 119 +++++++++++
 tb/tb_qar_adc_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qar_adc_arbiter_pkg.sv
// qar_adc_arb_pkg: FSM states, ADC register map and CTRL word builder shared by the arbiter files.
package qar_adc_arb_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_READ, S_RESP} state_e;
    localparam logic [4:0] ADC_CTRL   = 5'd0;
    localparam logic [4:0] ADC_STATUS = 5'd1;
    localparam logic [4:0] ADC_DATA   = 5'd2;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_CH    = 4;
    localparam int ST_BUSY    = 0;
    localparam int ST_DV      = 1;
    localparam int DATA_CH    = 16;
    // Manual one-shot conversion on ch: enable + start, continuous mode left off.
    function automatic logic [31:0] ctrl_word(input logic [1:0] ch);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN] = 1'b1;
        w[CTRL_CONT] = 1'b0;
        w[CTRL_START] = 1'b1;
        w[CTRL_CH +: 2] = ch;
        return w;
    endfunction
endpackage

// File: rtl/qar_adc_arbiter_if.sv
// qar_adc_arbiter_if: requester handshake plus ADC register-port signals of the arbiter.
interface qar_adc_arbiter_if #(parameter int N_REQ = 4, parameter int WIDTH = 12);
    logic [N_REQ-1:0]   req_valid;
    logic [2*N_REQ-1:0] req_channel;
    logic [N_REQ-1:0]   req_ack;
    logic [N_REQ-1:0]   resp_valid;
    logic [WIDTH-1:0]   resp_data;
    logic [1:0]         resp_channel;
    logic               resp_error;
    logic               busy;
    logic               adc_write;
    logic               adc_read;
    logic [4:0]         adc_addr;
    logic [31:0]        adc_wdata;
    logic [31:0]        adc_rdata;
    modport master (
        input  req_valid, req_channel, adc_rdata,
        output req_ack, resp_valid, resp_data, resp_channel, resp_error, busy,
               adc_write, adc_read, adc_addr, adc_wdata
    );
    modport slave (
        output req_valid, req_channel, adc_rdata,
        input  req_ack, resp_valid, resp_data, resp_channel, resp_error, busy,
               adc_write, adc_read, adc_addr, adc_wdata
    );
endinterface

// File: rtl/qar_adc_arbiter_rr_picker.sv
// qar_rr_picker: combinational round-robin pick of the first set request at or after the pointer.
module qar_rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o
);
    // Scan from farthest to nearest so the nearest set bit overwrites any earlier pick.
    always_comb begin
        int j;
        j = 0;
        grant_o = '0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                grant_o = '0;
                grant_o[j] = 1'b1;
                idx_o = PW'(j);
            end
        end
    end
endmodule

// File: rtl/qar_adc_arbiter.sv
// qar_adc_arbiter: round-robin sharing of one manual-mode ADC between N_REQ one-shot requesters.
module qar_adc_arbiter
    import qar_adc_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 12,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    qar_adc_arbiter_if.master bus
);
    localparam int PW = $clog2(N_REQ);
    state_e             state_q;
    logic [PW-1:0]      rr_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [1:0]         ch_q;
    logic               seen_q;
    logic [15:0]        cnt_q;
    logic [N_REQ-1:0]   resp_valid_q;
    logic [WIDTH-1:0]   resp_data_q;
    logic [1:0]         resp_ch_q;
    logic               resp_err_q;
    logic               adc_write_q;
    logic               adc_read_q;
    logic [4:0]         adc_addr_q;
    logic [31:0]        adc_wdata_q;
    logic [N_REQ-1:0]   grant_d;
    logic [PW-1:0]      gidx_d;
    logic [1:0]         gch_d;
    logic               st_busy;
    logic               done;
    logic               unused_rdata;
    qar_rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
        .req_i(bus.req_valid), .ptr_i(rr_q), .grant_o(grant_d), .idx_o(gidx_d)
    );
    assign gch_d        = bus.req_channel[{gidx_d, 1'b0} +: 2];
    assign st_busy      = bus.adc_rdata[ST_BUSY];
    // A data_valid only counts once busy has been observed, so stale results are ignored.
    assign done         = seen_q && bus.adc_rdata[ST_DV] && !st_busy;
    assign unused_rdata = ^bus.adc_rdata;
    assign bus.req_ack      = (state_q == S_IDLE) ? grant_d : '0;
    assign bus.busy         = state_q != S_IDLE;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_channel = resp_ch_q;
    assign bus.resp_error   = resp_err_q;
    assign bus.adc_write    = adc_write_q;
    assign bus.adc_read     = adc_read_q;
    assign bus.adc_addr     = adc_addr_q;
    assign bus.adc_wdata    = adc_wdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q <= '0;
            gnt_q <= '0;
            ch_q <= '0;
            seen_q <= 1'b0;
            cnt_q <= '0;
            resp_valid_q <= '0;
            resp_data_q <= '0;
            resp_ch_q <= '0;
            resp_err_q <= 1'b0;
            adc_write_q <= 1'b0;
            adc_read_q <= 1'b0;
            adc_addr_q <= '0;
            adc_wdata_q <= '0;
        end else begin
            adc_write_q <= 1'b0;
            adc_read_q <= 1'b0;
            adc_addr_q <= ADC_CTRL;
            adc_wdata_q <= '0;
            resp_valid_q <= '0;
            resp_err_q <= 1'b0;
            case (state_q)
                S_IDLE: if (|bus.req_valid) begin
                    gnt_q <= grant_d;
                    ch_q <= gch_d;
                    rr_q <= (gidx_d == PW'(N_REQ - 1)) ? '0 : gidx_d + 1'b1;
                    seen_q <= 1'b0;
                    cnt_q <= '0;
                    state_q <= S_START;
                    adc_write_q <= 1'b1;
                    adc_wdata_q <= ctrl_word(gch_d);
                end
                S_START: begin
                    state_q <= S_WAIT;
                    adc_read_q <= 1'b1;
                    adc_addr_q <= ADC_STATUS;
                end
                S_WAIT: begin
                    seen_q <= seen_q | st_busy;
                    if (done) begin
                        state_q <= S_READ;
                        adc_read_q <= 1'b1;
                        adc_addr_q <= ADC_DATA;
                    end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                        state_q <= S_RESP;
                        resp_valid_q <= gnt_q;
                        resp_err_q <= 1'b1;
                        resp_data_q <= '0;
                        resp_ch_q <= ch_q;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        adc_read_q <= 1'b1;
                        adc_addr_q <= ADC_STATUS;
                    end
                end
                S_READ: begin
                    state_q <= S_RESP;
                    resp_valid_q <= gnt_q;
                    resp_data_q <= bus.adc_rdata[WIDTH-1:0];
                    resp_ch_q <= bus.adc_rdata[DATA_CH +: 2];
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qar_adc_arbiter.sv
// tb_qar_adc_arbiter: directed scenarios against a behavioural ADC stub.
// Stub: a start write loads a 9-cycle busy window (optionally delayed), after which data_valid rises.
module tb_qar_adc_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    qar_adc_arbiter_if #(.N_REQ(4), .WIDTH(12)) bus();
    qar_adc_arbiter #(.N_REQ(4), .WIDTH(12), .TIMEOUT(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_vec = 0;
    int n_err = 0;
    logic [11:0] ch_val [4] = '{12'h123, 12'h456, 12'h5A3, 12'h789};
    logic no_busy = 1'b0;
    logic inject = 1'b0;
    int start_dly = 0;
    int dly = 0;
    int cnt = 0;
    logic dv = 1'b0;
    logic [11:0] dval = '0;
    logic [1:0] dch = '0;
    logic [1:0] pch = '0;
    logic sbusy;
    always @(posedge clk) begin
        if (inject) begin
            dv <= 1'b1;
            dval <= 12'h111;
            dch <= 2'd2;
        end
        if (bus.adc_write && bus.adc_addr == 5'd0 && bus.adc_wdata[2] && !no_busy) begin
            dly <= start_dly;
            cnt <= 9;
            pch <= bus.adc_wdata[5:4];
        end else if (dly != 0) dly <= dly - 1;
        else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                dv <= 1'b1;
                dval <= ch_val[pch];
                dch <= pch;
            end
        end
        if (bus.adc_read && bus.adc_addr == 5'd2) dv <= 1'b0;
    end
    assign sbusy = (dly == 0) && (cnt != 0);
    assign bus.adc_rdata = !bus.adc_read ? 32'h0 :
                           bus.adc_addr == 5'd1 ? {30'h0, dv, sbusy} :
                           bus.adc_addr == 5'd2 ? {14'h0, dch, 4'h0, dval} : 32'h0;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_resp(output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.resp_valid != 0) begin
                k = i;
                return;
            end
        end
    endtask
    task automatic wait_ack(output int k);
        k = -1;
        for (int i = 0; i <= 60; i++) begin
            if (bus.req_ack != 0) begin
                k = i;
                return;
            end
            tick();
        end
    endtask
    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.req_ack, bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error, bus.busy} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_resp: got %h want 0", {bus.req_ack, bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error, bus.busy});
        end
        n_vec++;
        if ({bus.adc_write, bus.adc_read, bus.adc_addr, bus.adc_wdata} !== 39'h0) begin
            n_err++;
            $display("FAIL reset_adc: got %h want 0", {bus.adc_write, bus.adc_read, bus.adc_addr, bus.adc_wdata});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask
    task automatic test_single;
        int k;
        bus.req_channel = 8'b00_00_10_00;
        bus.req_valid = 4'b0010;
        #1;
        n_vec++;
        if (bus.req_ack !== 4'b0010) begin n_err++; $display("FAIL single_ack: got %b want 0010", bus.req_ack); end
        tick();
        bus.req_valid = 4'b0000;
        n_vec++;
        if ({bus.busy, bus.adc_write, bus.adc_addr, bus.adc_wdata} !== {1'b1, 1'b1, 5'd0, 32'h25}) begin
            n_err++;
            $display("FAIL single_start: got %h want %h", {bus.busy, bus.adc_write, bus.adc_addr, bus.adc_wdata}, {1'b1, 1'b1, 5'd0, 32'h25});
        end
        wait_resp(k);
        n_vec++;
        if (k + 1 !== 13) begin n_err++; $display("FAIL single_latency: got %0d want 13", k + 1); end
        n_vec++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error} !== {4'b0010, 12'h5A3, 2'd2, 1'b0}) begin
            n_err++;
            $display("FAIL single_resp: got %h want %h", {bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error}, {4'b0010, 12'h5A3, 2'd2, 1'b0});
        end
        tick();
        n_vec++;
        if ({bus.resp_valid, bus.busy} !== 5'b0) begin n_err++; $display("FAIL single_idle: got %b want 00000", {bus.resp_valid, bus.busy}); end
    endtask
    task automatic test_round_robin;
        int k;
        int e;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.req_channel = 8'b11_10_01_00;
        bus.req_valid = 4'b1111;
        #1;
        wait_ack(k);
        n_vec++;
        if (k !== 0) begin n_err++; $display("FAIL rr_first_ack: got %0d cycles want 0", k); end
        for (int n = 0; n < 5; n++) begin
            e = n % 4;
            n_vec++;
            if (bus.req_ack !== (4'b1 << e)) begin n_err++; $display("FAIL rr_ack%0d: got %b want %b", n, bus.req_ack, 4'b1 << e); end
            wait_resp(k);
            n_vec++;
            if ({bus.resp_valid, bus.resp_data, bus.resp_channel} !== {4'b1 << e, ch_val[e], 2'(e)}) begin
                n_err++;
                $display("FAIL rr_resp%0d: got %h want %h", n, {bus.resp_valid, bus.resp_data, bus.resp_channel}, {4'b1 << e, ch_val[e], 2'(e)});
            end
            if (n == 4) bus.req_valid = 4'b0000;
            tick();
        end
        n_vec++;
        if (bus.req_ack !== 4'b0000) begin n_err++; $display("FAIL rr_drained: got %b want 0000", bus.req_ack); end
    endtask
    task automatic test_stale;
        int k;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        start_dly = 3;
        bus.req_channel = 8'b00_10_00_00;
        bus.req_valid = 4'b0100;
        #1;
        n_vec++;
        if (bus.req_ack !== 4'b0100) begin n_err++; $display("FAIL stale_ack: got %b want 0100", bus.req_ack); end
        tick();
        bus.req_valid = 4'b0000;
        wait_resp(k);
        n_vec++;
        if (k + 1 !== 16) begin n_err++; $display("FAIL stale_latency: got %0d want 16", k + 1); end
        n_vec++;
        if ({bus.resp_data, bus.resp_channel, bus.resp_error} !== {12'h5A3, 2'd2, 1'b0}) begin
            n_err++;
            $display("FAIL stale_data: got %h want %h", {bus.resp_data, bus.resp_channel, bus.resp_error}, {12'h5A3, 2'd2, 1'b0});
        end
        start_dly = 0;
        tick();
    endtask
    task automatic test_timeout;
        int k;
        no_busy = 1'b1;
        bus.req_channel = 8'b00_00_00_01;
        bus.req_valid = 4'b0001;
        #1;
        n_vec++;
        if (bus.req_ack !== 4'b0001) begin n_err++; $display("FAIL to_ack: got %b want 0001", bus.req_ack); end
        tick();
        bus.req_valid = 4'b0000;
        wait_resp(k);
        n_vec++;
        if (k + 1 !== 22) begin n_err++; $display("FAIL to_latency: got %0d want 22", k + 1); end
        n_vec++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error} !== {4'b0001, 12'h000, 2'd1, 1'b1}) begin
            n_err++;
            $display("FAIL to_resp: got %h want %h", {bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error}, {4'b0001, 12'h000, 2'd1, 1'b1});
        end
        tick();
        n_vec++;
        if (bus.resp_error !== 1'b0) begin n_err++; $display("FAIL to_err_pulse: got %b want 0", bus.resp_error); end
        no_busy = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        tick();
        bus.req_valid = 4'b0000;
        wait_resp(k);
        n_vec++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error} !== {4'b0001, 12'h456, 2'd1, 1'b0} || k !== 12) begin
            n_err++;
            $display("FAIL to_recover: got %h after %0d want %h after 12", {bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error}, k, {4'b0001, 12'h456, 2'd1, 1'b0});
        end
        tick();
        tick();
        tick();
        n_vec++;
        if (bus.resp_data !== 12'h456) begin n_err++; $display("FAIL data_hold: got %h want 456", bus.resp_data); end
    endtask
    task automatic test_reset_midwait;
        int k;
        logic got;
        bus.req_channel = 8'b00_00_11_00;
        bus.req_valid = 4'b0010;
        #1;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        tick();
        n_vec++;
        if ({bus.busy, bus.adc_read, bus.adc_addr} !== {1'b1, 1'b1, 5'd1}) begin
            n_err++;
            $display("FAIL mid_wait: got %h want %h", {bus.busy, bus.adc_read, bus.adc_addr}, {1'b1, 1'b1, 5'd1});
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.req_ack, bus.busy, bus.adc_read, bus.adc_addr, bus.resp_data} !== 23'h0) begin
            n_err++;
            $display("FAIL mid_reset: got %h want 0", {bus.req_ack, bus.busy, bus.adc_read, bus.adc_addr, bus.resp_data});
        end
        tick();
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.resp_valid != 0) got = 1'b1;
        end
        n_vec++;
        if (got !== 1'b0) begin n_err++; $display("FAIL mid_no_resp: got %b want 0", got); end
        bus.req_channel = 8'b00_00_00_00;
        bus.req_valid = 4'b0100;
        #1;
        n_vec++;
        if (bus.req_ack !== 4'b0100) begin n_err++; $display("FAIL mid_fresh_ack: got %b want 0100", bus.req_ack); end
        tick();
        bus.req_valid = 4'b0000;
        wait_resp(k);
        n_vec++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error} !== {4'b0100, 12'h123, 2'd0, 1'b0} || k !== 12) begin
            n_err++;
            $display("FAIL mid_fresh_resp: got %h after %0d want %h after 12", {bus.resp_valid, bus.resp_data, bus.resp_channel, bus.resp_error}, k, {4'b0100, 12'h123, 2'd0, 1'b0});
        end
        tick();
    endtask
    task automatic test_back_to_back;
        int k;
        bus.req_channel = 8'b10_00_11_01;
        bus.req_valid = 4'b0001;
        #1;
        n_vec++;
        if (bus.req_ack !== 4'b0001) begin n_err++; $display("FAIL b2b_ack0: got %b want 0001", bus.req_ack); end
        tick();
        bus.req_valid = 4'b0000;
        wait_resp(k);
        bus.req_valid = 4'b1000;
        tick();
        n_vec++;
        if (bus.req_ack !== 4'b1000) begin n_err++; $display("FAIL b2b_ack3: got %b want 1000", bus.req_ack); end
        tick();
        bus.req_valid = 4'b0010;
        wait_resp(k);
        n_vec++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_channel} !== {4'b1000, 12'h5A3, 2'd2} || k !== 12) begin
            n_err++;
            $display("FAIL b2b_resp3: got %h after %0d want %h after 12", {bus.resp_valid, bus.resp_data, bus.resp_channel}, k, {4'b1000, 12'h5A3, 2'd2});
        end
        tick();
        n_vec++;
        if (bus.req_ack !== 4'b0010) begin n_err++; $display("FAIL b2b_ack1: got %b want 0010", bus.req_ack); end
        tick();
        bus.req_valid = 4'b0000;
        wait_resp(k);
        n_vec++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_channel} !== {4'b0010, 12'h789, 2'd3} || k !== 12) begin
            n_err++;
            $display("FAIL b2b_resp1: got %h after %0d want %h after 12", {bus.resp_valid, bus.resp_data, bus.resp_channel}, k, {4'b0010, 12'h789, 2'd3});
        end
        tick();
    endtask
    initial begin
        bus.req_valid = 4'b0000;
        bus.req_channel = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_stale();
        test_timeout();
        test_reset_midwait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within budget");
        $fatal(1, "watchdog expired");
    end
endmodule
